// File: rtl/vend_ledger.sv
// -----------------------------------------------------------------------------
// vend_ledger
//   Stock, sales and payment ledger for the vending machine. Keeps a stock and
//   sold counter per product channel, accepts single-cycle commands from the
//   front-end controller, collects coins, commits a sale once it is fully paid
//   and then pays the change out one coin per cycle.
//
//   Optional feature macro: VEND_AUDIT_EN
//     defined   : o_err_cnt counts rejected commands (saturating at 255),
//                 cleared by reset and by CLEAR.
//     undefined : o_err_cnt is tied to 0.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_cmd_valid    command strobe, taken when o_cmd_ready=1
//   i_cmd_op       0 SELECT 1 QTY_UP 2 QTY_DN 3 COIN 4 CANCEL 5 RESTOCK 6 CLEAR
//   i_cmd_arg      item id / coin value / restock count
//   o_cmd_ready    high in IDLE and COLLECT
//   o_rsp_ack      pulse: previous accepted command succeeded
//   o_rsp_err      pulse: previous accepted command rejected
//   o_sel_id       selected item
//   o_sel_qty      purchase quantity
//   o_sel_stock    stock of the selected item
//   o_sel_sold     sold count of the selected item
//   o_sold_out     selected item has no stock
//   o_due          quantity * price of the selected item
//   o_paid         coins inserted in this transaction
//   o_sale_total   cumulative revenue, saturating
//   o_chg_valid    change coin ejected this cycle
//   o_chg_coin     value of the ejected coin (10/5/2/1)
//   o_busy         paying out change
//   o_err_cnt      audit counter of rejected commands
// -----------------------------------------------------------------------------
module vend_ledger #(
    parameter int NUM_ITEMS  = 4,
    parameter int CNT_W      = 4,
    parameter int BASE_PRICE = 3,
    parameter int MONEY_W    = 7,
    parameter int SALE_W     = 10,
    localparam int IDW       = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_cmd_valid,
    input  logic [2:0]         i_cmd_op,
    input  logic [7:0]         i_cmd_arg,
    output logic               o_cmd_ready,
    output logic               o_rsp_ack,
    output logic               o_rsp_err,
    output logic [IDW-1:0]     o_sel_id,
    output logic [CNT_W-1:0]   o_sel_qty,
    output logic [CNT_W-1:0]   o_sel_stock,
    output logic [CNT_W-1:0]   o_sel_sold,
    output logic               o_sold_out,
    output logic [MONEY_W-1:0] o_due,
    output logic [MONEY_W-1:0] o_paid,
    output logic [SALE_W-1:0]  o_sale_total,
    output logic               o_chg_valid,
    output logic [3:0]         o_chg_coin,
    output logic               o_busy,
    output logic [7:0]         o_err_cnt
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int PROD_W  = MONEY_W + CNT_W + 1;

    localparam logic [2:0] OP_SELECT  = 3'd0;
    localparam logic [2:0] OP_QTY_UP  = 3'd1;
    localparam logic [2:0] OP_QTY_DN  = 3'd2;
    localparam logic [2:0] OP_COIN    = 3'd3;
    localparam logic [2:0] OP_CANCEL  = 3'd4;
    localparam logic [2:0] OP_RESTOCK = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_CHANGE  = 2'd2
    } state_t;

    function automatic logic [MONEY_W-1:0] price(input logic [IDW-1:0] id);
        return MONEY_W'(BASE_PRICE + int'(id));
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt_add(input logic [CNT_W-1:0] a,
                                                     input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? CNT_W'(CNT_MAX) : sum[CNT_W-1:0];
    endfunction

    function automatic logic [SALE_W-1:0] sat_sale_add(input logic [SALE_W-1:0]  a,
                                                       input logic [MONEY_W-1:0] b);
        logic [SALE_W:0] sum;
        sum = {1'b0, a} + (SALE_W+1)'(b);
        return sum[SALE_W] ? {SALE_W{1'b1}} : sum[SALE_W-1:0];
    endfunction

    // Greedy denomination choice; with 10/5/2/1 this always yields the exact
    // remaining amount.
    function automatic logic [3:0] largest_coin(input logic [MONEY_W-1:0] rem);
        if (int'(rem) >= 10)     return 4'd10;
        else if (int'(rem) >= 5) return 4'd5;
        else if (int'(rem) >= 2) return 4'd2;
        else if (int'(rem) >= 1) return 4'd1;
        else                     return 4'd0;
    endfunction

    state_t             r_state;
    logic [CNT_W-1:0]   r_stock [NUM_ITEMS];
    logic [CNT_W-1:0]   r_sold  [NUM_ITEMS];
    logic [IDW-1:0]     r_sel_id;
    logic [CNT_W-1:0]   r_sel_qty;
    logic [MONEY_W-1:0] r_paid;
    logic [SALE_W-1:0]  r_sale_total;
    logic [MONEY_W-1:0] r_chg_rem;
    logic               r_rsp_ack;
    logic               r_rsp_err;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_stock_nxt [NUM_ITEMS];
    logic [CNT_W-1:0]   w_sold_nxt  [NUM_ITEMS];
    logic [IDW-1:0]     w_sel_id_nxt;
    logic [CNT_W-1:0]   w_sel_qty_nxt;
    logic [MONEY_W-1:0] w_paid_nxt;
    logic [SALE_W-1:0]  w_sale_nxt;
    logic [MONEY_W-1:0] w_rem_nxt;
    logic               w_ack_nxt;
    logic               w_err_nxt;

    logic               w_accept;
    logic               w_clear;
    logic               w_commit;
    logic [IDW-1:0]     w_arg_id;
    logic [MONEY_W-1:0] w_price;
    logic [PROD_W-1:0]  w_due_full;
    logic [PROD_W-1:0]  w_due_up_full;
    logic [MONEY_W-1:0] w_due;
    logic [CNT_W-1:0]   w_cur_stock;
    logic [CNT_W-1:0]   w_left_stock;
    logic [8:0]         w_restock_sum;
    logic [MONEY_W:0]   w_coin_sum;
    logic               w_coin_ok;
    logic [3:0]         w_chg_coin;

    assign o_cmd_ready = (r_state != S_CHANGE);
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_clear     = w_accept && (r_state == S_IDLE) && (i_cmd_op == OP_CLEAR);
    assign w_arg_id    = i_cmd_arg[IDW-1:0];
    assign w_cur_stock = r_stock[r_sel_id];
    assign w_price     = price(r_sel_id);

    // Products are formed wide so that QTY_UP can see whether the next
    // quantity would push the due amount past the MONEY_W range.
    assign w_due_full    = PROD_W'(r_sel_qty) * PROD_W'(w_price);
    assign w_due_up_full = (PROD_W'(r_sel_qty) + PROD_W'(1)) * PROD_W'(w_price);
    assign w_due         = w_due_full[MONEY_W-1:0];

    assign w_restock_sum = 9'(w_cur_stock) + {1'b0, i_cmd_arg};
    assign w_coin_sum    = {1'b0, r_paid} + (MONEY_W+1)'(i_cmd_arg);
    assign w_coin_ok     = ((i_cmd_arg == 8'd1) || (i_cmd_arg == 8'd2) ||
                            (i_cmd_arg == 8'd5) || (i_cmd_arg == 8'd10)) &&
                           !w_coin_sum[MONEY_W];

    assign w_commit     = (r_state == S_COLLECT) && (r_paid >= w_due);
    assign w_left_stock = w_cur_stock - r_sel_qty;
    assign w_chg_coin   = largest_coin(r_chg_rem);

    always_comb begin
        w_state_nxt   = r_state;
        w_stock_nxt   = r_stock;
        w_sold_nxt    = r_sold;
        w_sel_id_nxt  = r_sel_id;
        w_sel_qty_nxt = r_sel_qty;
        w_paid_nxt    = r_paid;
        w_sale_nxt    = r_sale_total;
        w_rem_nxt     = r_chg_rem;
        w_ack_nxt     = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_err_nxt = 1'b1;
                    case (i_cmd_op)
                        OP_SELECT: begin
                            if (int'(i_cmd_arg) < NUM_ITEMS) begin
                                w_err_nxt     = 1'b0;
                                w_ack_nxt     = 1'b1;
                                w_sel_id_nxt  = w_arg_id;
                                w_sel_qty_nxt = (r_stock[w_arg_id] != '0) ? CNT_W'(1) : '0;
                            end
                        end
                        OP_QTY_UP: begin
                            if ((r_sel_qty != w_cur_stock) &&
                                (w_due_up_full[PROD_W-1:MONEY_W] == '0)) begin
                                w_err_nxt     = 1'b0;
                                w_ack_nxt     = 1'b1;
                                w_sel_qty_nxt = r_sel_qty + CNT_W'(1);
                            end
                        end
                        OP_QTY_DN: begin
                            if (r_sel_qty > CNT_W'(1)) begin
                                w_err_nxt     = 1'b0;
                                w_ack_nxt     = 1'b1;
                                w_sel_qty_nxt = r_sel_qty - CNT_W'(1);
                            end
                        end
                        OP_COIN: begin
                            if ((r_sel_qty != '0) && w_coin_ok) begin
                                w_err_nxt   = 1'b0;
                                w_ack_nxt   = 1'b1;
                                w_paid_nxt  = w_coin_sum[MONEY_W-1:0];
                                w_state_nxt = S_COLLECT;
                            end
                        end
                        OP_RESTOCK: begin
                            if (int'(w_restock_sum) <= CNT_MAX) begin
                                w_err_nxt = 1'b0;
                                w_ack_nxt = 1'b1;
                                w_stock_nxt[r_sel_id] = w_restock_sum[CNT_W-1:0];
                                // Only lift a zero quantity when there is now
                                // something to sell, so qty never exceeds stock.
                                if ((r_sel_qty == '0) && (w_restock_sum != 9'd0))
                                    w_sel_qty_nxt = CNT_W'(1);
                            end
                        end
                        OP_CLEAR: begin
                            w_err_nxt = 1'b0;
                            w_ack_nxt = 1'b1;
                        end
                        OP_CANCEL: begin
                            w_err_nxt = 1'b0;
                            w_ack_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            S_COLLECT: begin
                if (w_commit) begin
                    // Commit wins over any command presented in the same cycle.
                    w_err_nxt             = w_accept;
                    w_stock_nxt[r_sel_id] = w_left_stock;
                    w_sold_nxt[r_sel_id]  = sat_cnt_add(r_sold[r_sel_id], r_sel_qty);
                    w_sale_nxt            = sat_sale_add(r_sale_total, w_due);
                    w_rem_nxt             = r_paid - w_due;
                    w_paid_nxt            = '0;
                    w_sel_qty_nxt         = (w_left_stock != '0) ? CNT_W'(1) : '0;
                    w_state_nxt           = (r_paid != w_due) ? S_CHANGE : S_IDLE;
                end else if (w_accept) begin
                    w_err_nxt = 1'b1;
                    if (i_cmd_op == OP_COIN) begin
                        if (w_coin_ok) begin
                            w_err_nxt  = 1'b0;
                            w_ack_nxt  = 1'b1;
                            w_paid_nxt = w_coin_sum[MONEY_W-1:0];
                        end
                    end else if (i_cmd_op == OP_CANCEL) begin
                        w_err_nxt   = 1'b0;
                        w_ack_nxt   = 1'b1;
                        w_rem_nxt   = r_paid;
                        w_paid_nxt  = '0;
                        w_state_nxt = (r_paid != '0) ? S_CHANGE : S_IDLE;
                    end
                end
            end

            S_CHANGE: begin
                w_rem_nxt = r_chg_rem - MONEY_W'(w_chg_coin);
                if (w_rem_nxt == '0)
                    w_state_nxt = S_IDLE;
            end

            default: w_state_nxt = S_IDLE;
        endcase

        if (w_clear) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                w_stock_nxt[i] = '0;
                w_sold_nxt[i]  = '0;
            end
            w_sale_nxt    = '0;
            w_sel_qty_nxt = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                r_stock[i] <= '0;
                r_sold[i]  <= '0;
            end
            r_sel_id     <= '0;
            r_sel_qty    <= '0;
            r_paid       <= '0;
            r_sale_total <= '0;
            r_chg_rem    <= '0;
            r_rsp_ack    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_stock      <= w_stock_nxt;
            r_sold       <= w_sold_nxt;
            r_sel_id     <= w_sel_id_nxt;
            r_sel_qty    <= w_sel_qty_nxt;
            r_paid       <= w_paid_nxt;
            r_sale_total <= w_sale_nxt;
            r_chg_rem    <= w_rem_nxt;
            r_rsp_ack    <= w_ack_nxt;
            r_rsp_err    <= w_err_nxt;
        end
    end

`ifdef VEND_AUDIT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_err_cnt <= '0;
        else if (w_clear)
            r_err_cnt <= '0;
        else if (w_err_nxt && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign o_err_cnt = r_err_cnt;
`else
    assign o_err_cnt = 8'd0;
`endif

    assign o_rsp_ack    = r_rsp_ack;
    assign o_rsp_err    = r_rsp_err;
    assign o_sel_id     = r_sel_id;
    assign o_sel_qty    = r_sel_qty;
    assign o_sel_stock  = w_cur_stock;
    assign o_sel_sold   = r_sold[r_sel_id];
    assign o_sold_out   = (w_cur_stock == '0);
    assign o_due        = w_due;
    assign o_paid       = r_paid;
    assign o_sale_total = r_sale_total;
    assign o_busy       = (r_state == S_CHANGE);
    assign o_chg_valid  = (r_state == S_CHANGE);
    assign o_chg_coin   = (r_state == S_CHANGE) ? w_chg_coin : 4'd0;

endmodule

// File: tb/tb_vend_ledger.sv
// -----------------------------------------------------------------------------
// tb_vend_ledger
//   Self-checking bench for vend_ledger with default parameters. Expected
//   command responses and change coins are queued as stimulus is driven and
//   consumed by a monitor as the ledger produces them; ledger state is checked
//   directly between transactions.
// -----------------------------------------------------------------------------
module tb_vend_ledger;

    localparam logic [2:0] OP_SELECT  = 3'd0;
    localparam logic [2:0] OP_QTY_UP  = 3'd1;
    localparam logic [2:0] OP_QTY_DN  = 3'd2;
    localparam logic [2:0] OP_COIN    = 3'd3;
    localparam logic [2:0] OP_CANCEL  = 3'd4;
    localparam logic [2:0] OP_RESTOCK = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       cmd_ready, rsp_ack, rsp_err, sold_out, chg_valid, busy;
    logic [1:0] sel_id;
    logic [3:0] sel_qty, sel_stock, sel_sold, chg_coin;
    logic [6:0] due, paid;
    logic [9:0] sale_total;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_errs = 0;
    bit rsp_q[$];
    int coin_q[$];

    always #5 clk = ~clk;

    vend_ledger dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cmd_valid  (cmd_valid),
        .i_cmd_op     (cmd_op),
        .i_cmd_arg    (cmd_arg),
        .o_cmd_ready  (cmd_ready),
        .o_rsp_ack    (rsp_ack),
        .o_rsp_err    (rsp_err),
        .o_sel_id     (sel_id),
        .o_sel_qty    (sel_qty),
        .o_sel_stock  (sel_stock),
        .o_sel_sold   (sel_sold),
        .o_sold_out   (sold_out),
        .o_due        (due),
        .o_paid       (paid),
        .o_sale_total (sale_total),
        .o_chg_valid  (chg_valid),
        .o_chg_coin   (chg_coin),
        .o_busy       (busy),
        .o_err_cnt    (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_err_cnt();
`ifdef VEND_AUDIT_EN
        return exp_errs;
`else
        return 0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle in which the
    // response is visible.
    task automatic send(input logic [2:0] op, input logic [7:0] arg, input bit ok);
        int n = 0;
        while (!cmd_ready && n < 40) begin
            tick(1);
            n++;
        end
        if (n >= 40) chk("ready_timeout", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        rsp_q.push_back(ok);
        if (!ok) exp_errs++;
        tick(1);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 8'd0;
    endtask

    // Scoreboard consumer: responses and change coins
    initial begin
        bit e;
        int c;
        forever begin
            @(negedge clk);
            if (rsp_ack || rsp_err) begin
                chk("rsp_onehot", rsp_ack & rsp_err, 0);
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_ack | rsp_err, 0);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_ack", rsp_ack, e);
                end
            end
            if (chg_valid) begin
                if (coin_q.size() == 0) begin
                    chk("chg_unexpected", chg_valid, 0);
                end else begin
                    c = coin_q.pop_front();
                    chk("chg_coin", chg_coin, c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 8'd0;
        tick(3);
        chk("rst_sel_id", sel_id, 0);
        chk("rst_qty", sel_qty, 0);
        chk("rst_stock", sel_stock, 0);
        chk("rst_paid", paid, 0);
        chk("rst_sale", sale_total, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_chg_valid", chg_valid, 0);
        chk("rst_chg_coin", chg_coin, 0);
        chk("rst_ack_err", {rsp_ack, rsp_err}, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        tick(1);

        // Restock item 0
        send(OP_RESTOCK, 8'd5, 1);
        chk("r5_stock", sel_stock, 5);
        chk("r5_qty", sel_qty, 1);
        chk("r5_due", due, 3);

        // Item 2: stock 3, buy 3, pay 20, change 5
        send(OP_SELECT, 8'd2, 1);
        chk("sel2_qty", sel_qty, 0);
        chk("sel2_sold_out", sold_out, 1);
        send(OP_RESTOCK, 8'd3, 1);
        send(OP_QTY_UP, 8'd0, 1);
        send(OP_QTY_UP, 8'd0, 1);
        chk("i2_qty", sel_qty, 3);
        chk("i2_due", due, 15);
        send(OP_QTY_UP, 8'd0, 0);
        chk("i2_qty_cap", sel_qty, 3);
        send(OP_COIN, 8'd10, 1);
        coin_q.push_back(5);
        send(OP_COIN, 8'd10, 1);
        chk("i2_paid", paid, 20);
        tick(1);
        chk("i2_chg_valid", chg_valid, 1);
        chk("i2_busy", busy, 1);
        chk("i2_ready", cmd_ready, 0);
        chk("i2_stock", sel_stock, 0);
        chk("i2_sold", sel_sold, 3);
        chk("i2_sale", sale_total, 15);
        chk("i2_sold_out", sold_out, 1);
        chk("i2_qty_after", sel_qty, 0);
        tick(1);
        chk("i2_idle", busy, 0);
        chk("i2_chg_off", chg_valid, 0);

        // Item 3: price 6, pay 2+2+1+10=15, change 9 as 5,2,2
        send(OP_SELECT, 8'd3, 1);
        send(OP_RESTOCK, 8'd2, 1);
        chk("i3_due", due, 6);
        send(OP_COIN, 8'd2, 1);
        send(OP_COIN, 8'd2, 1);
        send(OP_COIN, 8'd1, 1);
        coin_q.push_back(5);
        coin_q.push_back(2);
        coin_q.push_back(2);
        send(OP_COIN, 8'd10, 1);
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (!cmd_ready) busy_cycles++;
        end
        chk("i3_busy_cycles", busy_cycles, 3);
        chk("i3_stock", sel_stock, 1);
        chk("i3_sold", sel_sold, 1);
        chk("i3_sale", sale_total, 21);
        chk("i3_qty", sel_qty, 1);

        // Cancel with 3 paid: refund 2,1, nothing committed
        send(OP_COIN, 8'd2, 1);
        send(OP_COIN, 8'd1, 1);
        chk("cx_paid", paid, 3);
        coin_q.push_back(2);
        coin_q.push_back(1);
        send(OP_CANCEL, 8'd0, 1);
        tick(2);
        chk("cx_busy", busy, 0);
        chk("cx_paid0", paid, 0);
        chk("cx_stock", sel_stock, 1);
        chk("cx_sold", sel_sold, 1);
        chk("cx_sale", sale_total, 21);

        // Rejected commands leave state untouched
        send(OP_COIN, 8'd3, 0);
        chk("e_coin3_paid", paid, 0);
        chk("e_coin3_ready", busy, 0);
        send(OP_SELECT, 8'd4, 0);
        chk("e_sel4_id", sel_id, 3);
        send(OP_SELECT, 8'd0, 1);
        chk("sel0_qty", sel_qty, 1);
        send(OP_RESTOCK, 8'd12, 0);
        chk("e_rs12_stock", sel_stock, 5);
        send(OP_QTY_DN, 8'd0, 0);
        chk("e_qdn_qty", sel_qty, 1);

        // Command in the commit cycle is rejected; sale still commits
        coin_q.push_back(2);
        send(OP_COIN, 8'd5, 1);
        send(OP_CANCEL, 8'd0, 0);
        tick(1);
        chk("col_stock", sel_stock, 4);
        chk("col_sold", sel_sold, 1);
        chk("col_sale", sale_total, 24);
        chk("col_qty", sel_qty, 1);

        // Non-coin, non-cancel op while collecting
        send(OP_COIN, 8'd1, 1);
        send(OP_SELECT, 8'd1, 0);
        chk("e_colsel_id", sel_id, 0);
        coin_q.push_back(1);
        send(OP_CANCEL, 8'd0, 1);
        tick(1);
        chk("err_cnt", err_cnt, exp_err_cnt());

        // CLEAR
        send(OP_CLEAR, 8'd0, 1);
        chk("clr_stock", sel_stock, 0);
        chk("clr_sold", sel_sold, 0);
        chk("clr_sale", sale_total, 0);
        chk("clr_qty", sel_qty, 0);
        chk("clr_err_cnt", err_cnt, 0);

        // Reset in the middle of paying change 4 (2,2)
        send(OP_RESTOCK, 8'd4, 1);
        send(OP_QTY_UP, 8'd0, 1);
        chk("rm_due", due, 6);
        coin_q.push_back(2);
        send(OP_COIN, 8'd10, 1);
        tick(1);
        chk("rm_chg_valid", chg_valid, 1);
        rst_n = 1'b0;
        tick(1);
        chk("rm_chg_off", chg_valid, 0);
        chk("rm_busy", busy, 0);
        chk("rm_ready", cmd_ready, 1);
        chk("rm_stock", sel_stock, 0);
        chk("rm_sold", sel_sold, 0);
        chk("rm_sale", sale_total, 0);
        chk("rm_qty", sel_qty, 0);
        chk("rm_paid", paid, 0);
        rst_n = 1'b1;
        tick(2);
        chk("rm_still_idle", chg_valid, 0);

        chk("rsp_q_left", rsp_q.size(), 0);
        chk("coin_q_left", coin_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
